spike_encoder: RTL and testbench
================================

// Module: spike_encoder
// PURPOSE
//  Rate-codes an INPUT_NEURON-pixel frame into AER spike events over TIME_STEP steps; sits directly upstream of scheduler.
//  Per step: scans every pixel of the 1-cycle-latency pixel SRAM, pushes one event per spiking pixel, then one end-of-step marker.
//  Drives the scheduler push side (CTRL_SCHED_EVENT_IN/ADDR/VIRTS) and honours SCHED_FULL backpressure.
// PARAMETERS
//  TIME_STEP            8    time steps per frame (>=1)
//  INPUT_NEURON         784  pixels per frame
//  PRE_NEUR_ADDR_WIDTH  10   pixel/event address width (2^W >= INPUT_NEURON and >= TIME_STEP)
//  PIX_WIDTH            8    pixel intensity width
// PORTS
//  CLK                  in   1     clock
//  RSTN                 in   1     async active-low reset
//  START                in   1     1-cycle pulse: encode one frame (ignored unless IDLE)
//  BUSY                 out  1     high from START accept until DONE
//  DONE                 out  1     1-cycle pulse after last marker accepted
//  PIX_REN              out  1     pixel SRAM read enable
//  PIX_ADDR             out  W     pixel SRAM address
//  PIX_RDATA            in   PIX_WIDTH  read data, valid 1 cycle after PIX_REN
//  SCHED_FULL           in   1     scheduler FIFO full
//  CTRL_SCHED_EVENT_IN  out  1     push strobe
//  CTRL_SCHED_ADDR      out  W     event address
//  CTRL_SCHED_VIRTS     out  2     2'b00 = pixel spike, 2'b11 = end-of-step marker (ADDR = step index)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; step=0, pix=0; LFSR = 16'hACE1.
//  FSM: IDLE -START-> READ (PIX_REN=1, PIX_ADDR=pix) -> EVAL (PIX_RDATA valid, compute spike)
//       EVAL: spike -> PUSH, else NEXT. PUSH: hold until push accepted -> NEXT.
//       NEXT: pix==INPUT_NEURON-1 -> MARK, else pix++ -> READ.
//       MARK: hold until push accepted; step==TIME_STEP-1 -> FIN, else step++, pix=0 -> READ.
//       FIN: DONE=1 for one cycle, BUSY=0 -> IDLE.
//  Push rule: EVENT_IN asserted only in a cycle where SCHED_FULL==0; that cycle is the accept (scheduler drops pushes while full).
//   ADDR/VIRTS valid in the same cycle as EVENT_IN; at most one push per cycle; no event lost or duplicated under backpressure.
//  Deterministic coding: spike(t) = floor(p*(t+1)/2^PIX_WIDTH) > floor(p*t/2^PIX_WIDTH);
//   products are PIX_WIDTH+clog2(TIME_STEP+1) bits, unsigned, no truncation.
//   Frame total per pixel = floor(p*TIME_STEP/2^PIX_WIDTH).
//  Throughput: 3 cycles per non-spiking pixel, +1 per accepted spike, plus full-stall cycles.
//  START while BUSY: ignored. RSTN low mid-frame: immediate return to reset state, no DONE.
//  Marker is pushed even when no pixel spiked in that step.
// CONFIGURATION
//  `SPIKE_ENC_POISSON_EN defined:
//   - spike(t) = p > lfsr[PIX_WIDTH-1:0] (strict).
//   - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances once per EVAL cycle.
//   - LFSR reseeded to 16'hACE1 on START accept.
//  Undefined: deterministic coding above; LFSR logic absent.
// STRUCTURE
//  Shared package snn_ff_pkg:
//   - VIRTS_SPIKE=2'b00, VIRTS_MARK=2'b11
//   - LFSR_SEED=16'hACE1, LFSR tap mask
//   - FSM state encoding typedef
//  Sub-module spike_enc_lfsr: seed load + advance enable; instantiated only under `SPIKE_ENC_POISSON_EN.
// TESTING
//  1 All pixels 0, TIME_STEP=8, FULL=0 -> exactly 8 markers, ADDR 0..7, VIRTS=11, no spikes; then one DONE.
//  2 Pixel 5=255, 9=128, rest 0 (deterministic) -> pix5 spikes at t=1..7; pix9 at t=1,3,5,7; per-step order ascending addr then marker.
//  3 Test 2 with FULL toggling randomly ~50% -> identical event sequence at scheduler; EVENT_IN never high while FULL=1.
//  4 START pulsed again mid-frame -> ignored, single DONE, event count unchanged.
//  5 RSTN low mid-PUSH -> all outputs 0 next cycle; new START re-encodes the frame from step 0, pixel 0.
//  6 POISSON_EN, all pixels 255 -> per step 784-(#lfsr low bytes==255) spikes, matching bit-exact LFSR model from seed 16'hACE1.

Source files
------------

// File: rtl/snn_ff_pkg.sv
// Shared definitions for the feed-forward SNN front end: event tags, LFSR constants
// and the spike encoder FSM encoding.
package snn_ff_pkg;

  localparam logic [1:0]  VIRTS_SPIKE = 2'b00;
  localparam logic [1:0]  VIRTS_MARK  = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of the Fibonacci polynomial, as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_PUSH,
    ST_NEXT,
    ST_MARK,
    ST_FIN
  } enc_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Control, pixel-SRAM read port and scheduler push port of the spike encoder.
// master = encoder side, slave = surrounding system (SRAM, scheduler, controller).
interface spike_encoder_if #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8
) ();

  logic              START;
  logic              BUSY;
  logic              DONE;
  logic              PIX_REN;
  logic [ADDR_W-1:0] PIX_ADDR;
  logic [PIX_W-1:0]  PIX_RDATA;
  logic              SCHED_FULL;
  logic              CTRL_SCHED_EVENT_IN;
  logic [ADDR_W-1:0] CTRL_SCHED_ADDR;
  logic [1:0]        CTRL_SCHED_VIRTS;

  modport master (
    input  START, PIX_RDATA, SCHED_FULL,
    output BUSY, DONE, PIX_REN, PIX_ADDR,
           CTRL_SCHED_EVENT_IN, CTRL_SCHED_ADDR, CTRL_SCHED_VIRTS
  );

  modport slave (
    output START, PIX_RDATA, SCHED_FULL,
    input  BUSY, DONE, PIX_REN, PIX_ADDR,
           CTRL_SCHED_EVENT_IN, CTRL_SCHED_ADDR, CTRL_SCHED_VIRTS
  );

endinterface

// File: rtl/spike_enc_lfsr.sv
// 16-bit Fibonacci LFSR for Poisson spike coding; exists only when SPIKE_ENC_POISSON_EN is defined.
// load reseeds to LFSR_SEED, adv steps once; load wins if both are high.
`ifdef SPIKE_ENC_POISSON_EN
module spike_enc_lfsr
  import snn_ff_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  output logic [OUT_W-1:0] rnd
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (adv) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule
`endif

// File: rtl/spike_encoder.sv
// Rate-codes a pixel frame into AER spike events, one scan per time step, each step closed by a marker.
// Define SPIKE_ENC_POISSON_EN for LFSR-based Poisson coding instead of deterministic rate coding.
module spike_encoder
  import snn_ff_pkg::*;
#(
  parameter int TIME_STEP           = 8,
  parameter int INPUT_NEURON        = 784,
  parameter int PRE_NEUR_ADDR_WIDTH = 10,
  parameter int PIX_WIDTH           = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  spike_encoder_if.master bus
);

  localparam int W = PRE_NEUR_ADDR_WIDTH;
  localparam logic [W-1:0] PIX_LAST  = W'(INPUT_NEURON - 1);
  localparam logic [W-1:0] STEP_LAST = W'(TIME_STEP - 1);

  enc_state_e   state_q, state_d;
  logic [W-1:0] pix_q, pix_d;
  logic [W-1:0] step_q, step_d;
  logic         spike;

`ifdef SPIKE_ENC_POISSON_EN
  logic                 start_acc;
  logic [PIX_WIDTH-1:0] rnd;

  assign start_acc = (state_q == ST_IDLE) && bus.START;

  spike_enc_lfsr #(.OUT_W(PIX_WIDTH)) u_lfsr (
    .clk   (CLK),
    .rst_n (RSTN),
    .load  (start_acc),
    .adv   (state_q == ST_EVAL),
    .rnd   (rnd)
  );

  assign spike = bus.PIX_RDATA > rnd;
`else
  // p*(t+1) is formed as p*t + p; the width holds p*TIME_STEP without truncation.
  localparam int PROD_W = PIX_WIDTH + $clog2(TIME_STEP + 1);
  logic [PROD_W-1:0] prod_t, prod_t1;

  always_comb begin
    prod_t  = PROD_W'(bus.PIX_RDATA) * PROD_W'(step_q);
    prod_t1 = prod_t + PROD_W'(bus.PIX_RDATA);
  end

  assign spike = (prod_t1 >> PIX_WIDTH) > (prod_t >> PIX_WIDTH);
`endif

  // NOTE: every output and next-state value is defaulted first, so no branch can infer a latch.
  always_comb begin
    state_d                 = state_q;
    pix_d                   = pix_q;
    step_d                  = step_q;
    bus.BUSY                = 1'b0;
    bus.DONE                = 1'b0;
    bus.PIX_REN             = 1'b0;
    bus.PIX_ADDR            = '0;
    bus.CTRL_SCHED_EVENT_IN = 1'b0;
    bus.CTRL_SCHED_ADDR     = '0;
    bus.CTRL_SCHED_VIRTS    = VIRTS_SPIKE;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_READ;
          pix_d   = '0;
          step_d  = '0;
        end
      end
      ST_READ: begin
        bus.BUSY     = 1'b1;
        bus.PIX_REN  = 1'b1;
        bus.PIX_ADDR = pix_q;
        state_d      = ST_EVAL;
      end
      ST_EVAL: begin
        bus.BUSY = 1'b1;
        state_d  = spike ? ST_PUSH : ST_NEXT;
      end
      ST_PUSH: begin
        bus.BUSY            = 1'b1;
        bus.CTRL_SCHED_ADDR = pix_q;
        // The strobe is gated by FULL so every asserted strobe is an accepted push.
        if (!bus.SCHED_FULL) begin
          bus.CTRL_SCHED_EVENT_IN = 1'b1;
          state_d                 = ST_NEXT;
        end
      end
      ST_NEXT: begin
        bus.BUSY = 1'b1;
        if (pix_q == PIX_LAST) begin
          state_d = ST_MARK;
        end else begin
          pix_d   = pix_q + W'(1);
          state_d = ST_READ;
        end
      end
      ST_MARK: begin
        bus.BUSY             = 1'b1;
        bus.CTRL_SCHED_ADDR  = step_q;
        bus.CTRL_SCHED_VIRTS = VIRTS_MARK;
        if (!bus.SCHED_FULL) begin
          bus.CTRL_SCHED_EVENT_IN = 1'b1;
          if (step_q == STEP_LAST) begin
            state_d = ST_FIN;
          end else begin
            step_d  = step_q + W'(1);
            pix_d   = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_FIN: begin
        bus.DONE = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; the async reset clears them without a clock edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: event-level scoreboard fed by a frame model,
// plus frame-total, backpressure, restart-attempt and mid-frame reset scenarios.
module tb_spike_encoder;

  localparam int TS     = 8;
  localparam int NPIX   = 160;
  localparam int AW     = 10;
  localparam int PW     = 8;
  localparam int BUDGET = 20000;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;

  int full_mode = 0;
  int n_cmp     = 0;
  int n_err     = 0;
  int done_cnt  = 0;
  int mark_cnt  = 0;
  int obs_cnt  [NPIX];
  int obs_base [NPIX];

  logic [11:0]   exp_q [$];
  logic [PW-1:0] mem [NPIX];

  always #5 CLK = ~CLK;

  spike_encoder_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

  spike_encoder #(
    .TIME_STEP           (TS),
    .INPUT_NEURON        (NPIX),
    .PRE_NEUR_ADDR_WIDTH (AW),
    .PIX_WIDTH           (PW)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // Pixel SRAM with one cycle read latency.
  always @(posedge CLK) begin
    if (bus.PIX_REN) begin
      bus.PIX_RDATA <= (int'(bus.PIX_ADDR) < NPIX) ? mem[int'(bus.PIX_ADDR)] : '0;
    end
  end

  // Scheduler FULL: 0 = never full, 1 = always full, 2 = random ~50%.
  always @(posedge CLK) begin
    #1;
    case (full_mode)
      1:       bus.SCHED_FULL = 1'b1;
      2:       bus.SCHED_FULL = 1'($urandom_range(0, 1));
      default: bus.SCHED_FULL = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scheduler-side monitor: every strobe is an accept and must match the next expected event.
  always @(negedge CLK) begin
    int a;
    if (bus.DONE) done_cnt++;
    if (bus.CTRL_SCHED_EVENT_IN) begin
      a = int'(bus.CTRL_SCHED_ADDR);
      check("push_while_full", bus.SCHED_FULL, 0);
      if (bus.CTRL_SCHED_VIRTS == 2'b11) mark_cnt++;
      else if (a < NPIX) obs_cnt[a]++;
      if (exp_q.size() == 0)
        check("unexpected_event", {bus.CTRL_SCHED_VIRTS, bus.CTRL_SCHED_ADDR}, 32'hFFFF_FFFF);
      else
        check("event", {bus.CTRL_SCHED_VIRTS, bus.CTRL_SCHED_ADDR}, exp_q.pop_front());
    end
  end

`ifdef SPIKE_ENC_POISSON_EN
  // x^16 + x^14 + x^13 + x^11, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction
`endif

  // Whole-frame expected event list: ascending spiking pixels per step, then that step's marker.
  task automatic build_expected();
    bit s;
`ifdef SPIKE_ENC_POISSON_EN
    logic [15:0] l;
    l = 16'hACE1;
`endif
    exp_q.delete();
    for (int t = 0; t < TS; t++) begin
      for (int p = 0; p < NPIX; p++) begin
`ifdef SPIKE_ENC_POISSON_EN
        s = int'(mem[p]) > int'(l[PW-1:0]);
        l = lfsr_step(l);
`else
        s = (int'(mem[p]) * (t + 1)) / (1 << PW) > (int'(mem[p]) * t) / (1 << PW);
`endif
        if (s) exp_q.push_back({2'b00, 10'(p)});
      end
      exp_q.push_back({2'b11, 10'(t)});
    end
  endtask

`ifndef SPIKE_ENC_POISSON_EN
  task automatic check_totals(input string tag);
    for (int p = 0; p < NPIX; p++)
      check({tag, "_total"}, obs_cnt[p] - obs_base[p], (int'(mem[p]) * TS) / (1 << PW));
  endtask
`endif

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"},     bus.BUSY, 0);
    check({tag, "_done"},     bus.DONE, 0);
    check({tag, "_pix_ren"},  bus.PIX_REN, 0);
    check({tag, "_pix_addr"}, bus.PIX_ADDR, 0);
    check({tag, "_event_in"}, bus.CTRL_SCHED_EVENT_IN, 0);
    check({tag, "_ev_addr"},  bus.CTRL_SCHED_ADDR, 0);
    check({tag, "_virts"},    bus.CTRL_SCHED_VIRTS, 0);
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1 bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
  endtask

  // mid > 0 re-pulses START that many cycles into the frame.
  task automatic run_frame(input string tag, input int mid);
    int d0, m0, n;
    d0 = done_cnt;
    m0 = mark_cnt;
    n  = 0;
    obs_base = obs_cnt;
    pulse_start();
    @(negedge CLK);
    check({tag, "_busy"}, bus.BUSY, 1);
    while (done_cnt == d0 && n < BUDGET) begin
      @(posedge CLK);
      n++;
      #1 bus.START = (n == mid);
    end
    bus.START = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_markers"}, mark_cnt - m0, TS);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, bus.BUSY, 0);
  endtask

  initial begin
    bus.START = 1'b0;
    for (int p = 0; p < NPIX; p++) mem[p] = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    outputs_zero("reset");
    @(posedge CLK);
    #1 RSTN = 1'b1;

    // Blank frame: markers only.
    build_expected();
    run_frame("blank", 0);

    // Two bright pixels, no backpressure.
    mem[5] = 8'd255;
    mem[9] = 8'd128;
    build_expected();
    run_frame("pair", 0);
`ifndef SPIKE_ENC_POISSON_EN
    check("pair_pix5_spikes", obs_cnt[5] - obs_base[5], 7);
    check("pair_pix9_spikes", obs_cnt[9] - obs_base[9], 4);
    check_totals("pair");
`endif

    // Same frame under random backpressure.
    full_mode = 2;
    build_expected();
    run_frame("pair_bp", 0);

    // Random frame with bright first/last pixels; START re-pulsed mid-frame.
    for (int p = 0; p < NPIX; p++)
      mem[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : '0;
    mem[0]        = 8'd255;
    mem[NPIX - 1] = 8'd200;
    build_expected();
    run_frame("restart", 300);
`ifndef SPIKE_ENC_POISSON_EN
    check_totals("restart");
`endif

    // Reset while stalled on a push, then a clean re-encode.
    begin : mid_reset
      int m0, d0, n;
      full_mode = 0;
      for (int p = 0; p < NPIX; p++) mem[p] = '0;
      mem[3] = 8'd255;
      build_expected();
      m0 = mark_cnt;
      d0 = done_cnt;
      n  = 0;
      pulse_start();
      while (mark_cnt == m0 && n < BUDGET) begin
        @(posedge CLK);
        n++;
      end
      check("rst_first_marker", mark_cnt - m0, 1);
      full_mode = 1;
      repeat (40) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy_stalled", bus.BUSY, 1);
`ifndef SPIKE_ENC_POISSON_EN
      check("rst_stalled_addr", bus.CTRL_SCHED_ADDR, 3);
`endif
      @(posedge CLK);
      #1 RSTN = 1'b0;
      @(negedge CLK);
      outputs_zero("midreset");
      repeat (3) @(posedge CLK);
      check("rst_no_done", done_cnt - d0, 0);
      exp_q.delete();
      full_mode = 0;
      @(posedge CLK);
      #1 RSTN = 1'b1;
      build_expected();
      run_frame("rerun", 0);
    end

    // Saturated frame under random backpressure.
    full_mode = 2;
    for (int p = 0; p < NPIX; p++) mem[p] = 8'd255;
    build_expected();
    run_frame("sat", 0);
`ifndef SPIKE_ENC_POISSON_EN
    check_totals("sat");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
